// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and EX-operand forwarding control for a 5-stage LEGv8 pipeline.
// Stall/bubble/flush are combinational from ID inputs plus scoreboard; forwarding selects come straight from registered state.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             pc_src,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             id_bubble,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ie,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

    typedef enum logic {RUN, STALL} state_t;

    state_t state_q, state_d;

    logic             ex_vld_q, ex_rw_q, ex_mr_q, ex_urn_q, ex_urm_q;
    logic [REG_W-1:0] ex_rd_q, ex_rn_q, ex_rm_q;
    logic             mem_vld_q, mem_rw_q, mem_mr_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             wb_vld_q, wb_rw_q;
    logic [REG_W-1:0] wb_rd_q;

    logic             flush_act, ex_load;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    function automatic logic writes(input logic vld, input logic rw,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] r);
        return vld && rw && (rd == r) && (r != XZR);
    endfunction

    // pc_src is ignored while in reset so every flush output reads 0 then
    assign flush_act = pc_src && reset;

    always_comb begin
        ex_load = 1'b0;
        if (reset && id_valid && ex_mr_q) begin
            ex_load = (id_uses_rn && writes(ex_vld_q, ex_rw_q, ex_rd_q, id_rn)) ||
                      (id_uses_rm && writes(ex_vld_q, ex_rw_q, ex_rd_q, id_rm));
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        id_bubble  = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        flush_ie   = 1'b0;
        if (flush_act) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            flush_ie = 1'b1;
            state_d  = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_load) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        id_bubble  = 1'b1;
                        state_d    = STALL;
                    end
                end
                STALL: begin
                    // the load has moved to MEM; only a second dependent load re-stalls
                    state_d = RUN;
                    if (ex_load) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        id_bubble  = 1'b1;
                        state_d    = STALL;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            ex_vld_q  <= 1'b0;
            ex_rw_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            ex_urn_q  <= 1'b0;
            ex_urm_q  <= 1'b0;
            ex_rd_q   <= '0;
            ex_rn_q   <= '0;
            ex_rm_q   <= '0;
            mem_vld_q <= 1'b0;
            mem_rw_q  <= 1'b0;
            mem_mr_q  <= 1'b0;
            mem_rd_q  <= '0;
            wb_vld_q  <= 1'b0;
            wb_rw_q   <= 1'b0;
            wb_rd_q   <= '0;
        end else begin
            state_q  <= state_d;
            wb_vld_q <= mem_vld_q;
            wb_rw_q  <= mem_rw_q;
            wb_rd_q  <= mem_rd_q;
            if (flush_act) begin
                mem_vld_q <= 1'b0;
                mem_rw_q  <= 1'b0;
                mem_mr_q  <= 1'b0;
                mem_rd_q  <= '0;
            end else begin
                mem_vld_q <= ex_vld_q;
                mem_rw_q  <= ex_rw_q;
                mem_mr_q  <= ex_mr_q;
                mem_rd_q  <= ex_rd_q;
            end
            if (flush_act || id_bubble || !id_valid) begin
                ex_vld_q <= 1'b0;
                ex_rw_q  <= 1'b0;
                ex_mr_q  <= 1'b0;
                ex_urn_q <= 1'b0;
                ex_urm_q <= 1'b0;
                ex_rd_q  <= '0;
                ex_rn_q  <= '0;
                ex_rm_q  <= '0;
            end else begin
                ex_vld_q <= 1'b1;
                ex_rw_q  <= id_reg_write;
                ex_mr_q  <= id_mem_read;
                ex_urn_q <= id_uses_rn;
                ex_urm_q <= id_uses_rm;
                ex_rd_q  <= id_rd;
                ex_rn_q  <= id_rn;
                ex_rm_q  <= id_rm;
            end
        end
    end

    // a load sitting in MEM has no data on EX/MEM yet, so it only ever forwards from WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_urn_q) begin
            if (writes(mem_vld_q, mem_rw_q, mem_rd_q, ex_rn_q) && !mem_mr_q) begin
                fwd_a = 2'b10;
            end else if (writes(wb_vld_q, wb_rw_q, wb_rd_q, ex_rn_q)) begin
                fwd_a = 2'b01;
            end
        end
        if (ex_urm_q) begin
            if (writes(mem_vld_q, mem_rw_q, mem_rd_q, ex_rm_q) && !mem_mr_q) begin
                fwd_b = 2'b10;
            end else if (writes(wb_vld_q, wb_rw_q, wb_rd_q, ex_rm_q)) begin
                fwd_b = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (id_bubble && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_act && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: each vector queues its expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rn;
        logic       urn;
        logic [4:0] rm;
        logic       urm;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct packed {
        logic [2:0] ctl;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    localparam logic [2:0] GO  = 3'b110;
    localparam logic [2:0] BUB = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0, id_uses_rn = 1'b0, id_uses_rm = 1'b0;
    logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, pc_src = 1'b0;
    logic       pc_write, ifid_write, id_bubble, flush_if, flush_id, flush_ie;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt, flush_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .pc_src(pc_src), .pc_write(pc_write), .ifid_write(ifid_write), .id_bubble(id_bubble),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ie(flush_ie),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t ld(input int rd, input int rn);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn); i.urn = 1'b1; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t alu(input int rd, input int rn, input int rm);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rd = 5'(rd); i.rn = 5'(rn); i.rm = 5'(rm);
        i.urn = 1'b1; i.urm = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic logic [3:0] sat(input int v);
        return (v > 15) ? 4'd15 : 4'(v);
    endfunction

    task automatic drive(input instr_t i, input logic pcs);
        id_valid     = i.v;
        id_rn        = i.rn;
        id_uses_rn   = i.urn;
        id_rm        = i.rm;
        id_uses_rm   = i.urm;
        id_rd        = i.rd;
        id_reg_write = i.rw;
        id_mem_read  = i.mr;
        pc_src       = pcs;
    endtask

    // one vector per cycle: inputs change 1ns after the rising edge
    task automatic vec(input string nm, input logic rst, input instr_t i, input logic pcs,
                       input logic [2:0] ctl, input logic fl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [3:0] sc, input logic [3:0] fc,
                       input logic drop_rst);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        drive(i, pcs);
        e.ctl = ctl; e.fl = {3{fl}}; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (drop_rst) begin
            #1 reset = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {pc_write, ifid_write, id_bubble, flush_if, flush_id, flush_ie,
                  fwd_a, fwd_b, stall_cnt, flush_cnt};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got ctl=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, want ctl=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d",
                         nm, a.ctl, a.fl, a.fa, a.fb, a.sc, a.fc,
                         e.ctl, e.fl, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t r;
        // reset held low with random ID inputs
        for (int k = 0; k < 3; k++) begin
            r = instr_t'($urandom);
            vec("reset_hold", 1'b0, r, 1'(($urandom)), GO, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        end
        vec("reset_release", 1'b1, nop(), 1'b0, GO, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);

        // LDUR X2 ; ADD X3,X2,X4
        vec("lu_load",      1'b1, ld(2, 10),       1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        vec("lu_bubble",    1'b1, alu(3, 2, 4),    1'b0, BUB, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        vec("lu_release",   1'b1, alu(3, 2, 4),    1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("lu_fwd_wb",    1'b1, nop(),           1'b0, GO,  1'b0, 2'b01, 2'b00, 4'd1, 4'd0, 1'b0);

        // ADD X1 ; SUB X5,X1,X1
        vec("exf_add",      1'b1, alu(1, 20, 21),  1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("exf_sub",      1'b1, alu(5, 1, 1),    1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("exf_fwd_mem",  1'b1, nop(),           1'b0, GO,  1'b0, 2'b10, 2'b10, 4'd1, 4'd0, 1'b0);

        // ADD X1 ; ADD X1 ; ORR X6,X1,X7
        vec("pri_add_a",    1'b1, alu(1, 22, 23),  1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("pri_add_b",    1'b1, alu(1, 24, 25),  1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("pri_orr",      1'b1, alu(6, 1, 7),    1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("pri_mem_wins", 1'b1, nop(),           1'b0, GO,  1'b0, 2'b10, 2'b00, 4'd1, 4'd0, 1'b0);

        // XZR: load to X31 then reader, ALU write to X31 then reader
        vec("xzr_load",     1'b1, ld(31, 26),      1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("xzr_no_stall", 1'b1, alu(8, 31, 31),  1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("xzr_alu_wr",   1'b1, alu(31, 27, 28), 1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("xzr_reader",   1'b1, alu(10, 31, 31), 1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("xzr_no_fwd",   1'b1, nop(),           1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);

        // taken branch in the same cycle as a load-use hazard
        vec("br_load",      1'b1, ld(2, 11),       1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("br_over_stall",1'b1, alu(3, 2, 4),    1'b1, GO,  1'b1, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);
        vec("br_after",     1'b1, nop(),           1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);

        // dependent load chain re-stalls
        vec("dl_load4",     1'b1, ld(4, 12),       1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);
        vec("dl_load5_stl", 1'b1, ld(5, 4),        1'b0, BUB, 1'b0, 2'b00, 2'b00, 4'd1, 4'd1, 1'b0);
        vec("dl_load5_go",  1'b1, ld(5, 4),        1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd2, 4'd1, 1'b0);
        vec("dl_restall",   1'b1, alu(6, 5, 5),    1'b0, BUB, 1'b0, 2'b01, 2'b00, 4'd2, 4'd1, 1'b0);
        vec("dl_add_go",    1'b1, alu(6, 5, 5),    1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd3, 4'd1, 1'b0);
        vec("dl_fwd_wb",    1'b1, nop(),           1'b0, GO,  1'b0, 2'b01, 2'b01, 4'd3, 4'd1, 1'b0);

        // flush counter runs up and saturates
        for (int k = 0; k < 16; k++) begin
            vec("flush_sat", 1'b1, nop(), 1'b1, GO, 1'b1, 2'b00, 2'b00, 4'd3, sat(1 + k), 1'b0);
        end

        // LDUR X2,[X2] repeated: alternating bubble / advance until stall_cnt saturates
        for (int j = 0; j <= 30; j++) begin
            vec("stall_sat", 1'b1, ld(2, 2), 1'b0,
                (j % 2 == 1) ? BUB : GO, 1'b0,
                (j % 2 == 1 && j >= 3) ? 2'b01 : 2'b00, 2'b00,
                sat(3 + j / 2), 4'd15, 1'b0);
        end

        // async reset while a hazard is being signalled: outputs revert with no clock edge
        vec("rst_mid_stall", 1'b1, ld(2, 2), 1'b0, GO, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b1);
        vec("rst_low",       1'b0, ld(2, 2), 1'b0, GO, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        vec("rst_forgotten", 1'b1, ld(2, 2), 1'b0, GO, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        vec("post_rst_lu",   1'b1, alu(3, 2, 4), 1'b0, BUB, 1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 1'b0);
        vec("post_rst_go",   1'b1, alu(3, 2, 4), 1'b0, GO,  1'b0, 2'b00, 2'b00, 4'd1, 4'd0, 1'b0);

        @(posedge clk);
        #1 drive(nop(), 1'b0);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage LEGv8 pipeline (fetch, decode, execute, memory, writeback). It keeps a shadow scoreboard of the destination registers in flight, detects load-use hazards, and generates stall, bubble and flush controls for the fetch, decode and execute boundaries. It also produces the forwarding selects for the execute-stage ALU operands. It sits beside the datapath at the pipeline top level and is the single owner of all pipeline-register enable and flush decisions.

## Interface
- REG_W, default 5: register address width.
- ZERO_REG, default 31: XZR index; never a hazard source, never forwarded.
- CNT_W, default 16: width of the performance counters.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- id_valid  in  1  decode stage holds a real instruction.
- id_rn, id_rm  in  REG_W  source register addresses of the decoding instruction.
- id_uses_rn, id_uses_rm  in  1  the source is actually read.
- id_rd  in  REG_W  destination of the decoding instruction.
- id_reg_write, id_mem_read  in  1  decode-stage control bits.
- pc_src  in  1  branch taken, resolved in the memory stage this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- id_bubble  out  1  load zeroed controls into ID/EX.
- flush_if, flush_id, flush_ie  out  1  squash IF/ID, ID/EX and EX/MEM contents.
- fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB write data.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {valid, rd, reg_write, mem_read}. The EX entry also holds rn, rm, uses_rn and uses_rm.
- Every rising edge the scoreboard advances:
  - WB takes MEM.
  - MEM takes EX, or an empty entry if a flush is active.
  - EX takes the ID fields, or an empty entry if a bubble or flush is active, or if id_valid is 0.
- An entry "writes r" when valid and reg_write are both 1, rd == r, and r != ZERO_REG.
- Load-use hazard (combinational) when all hold:
  - id_valid is 1.
  - The EX entry is valid, has mem_read=1, and writes r.
  - r equals id_rn with id_uses_rn=1, or id_rm with id_uses_rm=1.
- FSM with two states:
  - RUN: no hazard gives pc_write=1, ifid_write=1, id_bubble=0. A hazard gives pc_write=0, ifid_write=0, id_bubble=1, and the next state is STALL.
  - STALL: held exactly one cycle, because the load has moved to MEM. Hazard detection is re-run; it normally clears, giving RUN. A second dependent load re-stalls.
- Flush: pc_src=1 forces flush_if=flush_id=flush_ie=1, pc_write=1, ifid_write=1 and id_bubble=0, and the next state is RUN.
  - pc_src overrides a load-use stall in the same cycle.
  - The stall is not counted in that case.
- Forwarding for fwd_a (EX.rn, only if EX.uses_rn):
  - 10 if the MEM entry writes EX.rn and that entry has mem_read=0.
  - Otherwise 01 if the WB entry writes EX.rn.
  - Otherwise 00.
  - MEM has priority over WB.
  - fwd_b is computed the same way using EX.rm.
- A load in MEM is never forwarded from EX/MEM. The stall guarantees the consumer reaches EX only when the load is in WB.
- Counters:
  - stall_cnt increments on each cycle id_bubble=1.
  - flush_cnt increments on each cycle pc_src=1.
  - Both saturate at all-ones.

## Timing
- While reset is low:
  - Scoreboard entries are invalid and the FSM is in RUN.
  - Counters are 0.
  - pc_write=1, ifid_write=1, id_bubble=0, all flushes 0, fwd_a=fwd_b=00.
- Reset deassertion mid-stall: the FSM returns to RUN and the in-flight hazard is forgotten. The datapath is reset simultaneously.
- Stall, bubble and flush outputs are combinational from current ID inputs and registered state, with zero-cycle latency. They must settle before the next rising edge.
- Forwarding selects depend only on registered state; they are glitch-free from clock-to-q.
- Load-use costs exactly one bubble cycle. A taken branch costs three squashed slots.

## Test plan
- Reset: hold reset low for 3 cycles with random ID inputs -> all outputs at the reset values above and counters 0. Release -> pc_write=1.
- Load-use: LDUR X2 followed by ADD X3,X2,X4 -> one cycle of pc_write=0, ifid_write=0, id_bubble=1. The next cycle the ADD is in EX with fwd_a=01. stall_cnt=1.
- EX forwarding: ADD X1 followed by SUB X5,X1,X1 -> with the SUB in EX, fwd_a=fwd_b=10 and no stall.
- Priority and XZR:
  - ADD X1; ADD X1; ORR X6,X1,... -> fwd_a=10 (MEM wins over WB).
  - A writer to X31 followed by a reader of X31 -> fwd 00, no stall.
- Branch flush over a stall: pc_src=1 in the same cycle as a load-use hazard -> flush_if=flush_id=flush_ie=1, id_bubble=0, pc_write=1. flush_cnt increments and stall_cnt is unchanged.
- Saturation and async reset: preload the counters near all-ones via repeated flushes, check they hold at all-ones. Drop reset mid-STALL -> outputs return to reset values immediately, with no clock edge.
